// File: rtl/gppm_pkg.sv
// Shared constants for the gppm switch front end: channel count, debounce timing and counter width.
package gppm_pkg;

  localparam int unsigned SW_W          = 8;
  // 5 ms at 50 MHz.
  localparam int unsigned DB_CYCLES     = 250000;
  localparam int unsigned DB_CYCLES_SIM = 4;
  localparam int unsigned CNT_W         = 18;

endpackage

// File: rtl/sw_conditioner_if.sv
// Switch conditioner bundle: raw pins in, debounced levels, edge strobes and toggle latches out.
interface sw_conditioner_if #(
  parameter int unsigned SW_W = gppm_pkg::SW_W
);

  logic [SW_W-1:0] sw_raw;
  logic [SW_W-1:0] sw_db;
  logic [SW_W-1:0] sw_rise;
  logic [SW_W-1:0] sw_fall;
  logic            sw_changed;
  logic [SW_W-1:0] sw_tgl;

  modport master (
    output sw_raw,
    input  sw_db,
    input  sw_rise,
    input  sw_fall,
    input  sw_changed,
    input  sw_tgl
  );

  modport slave (
    input  sw_raw,
    output sw_db,
    output sw_rise,
    output sw_fall,
    output sw_changed,
    output sw_tgl
  );

endinterface

// File: rtl/sw_debounce_bit.sv
// One switch channel: 2-flop synchroniser, counter debouncer and registered rise/fall strobes.
module sw_debounce_bit #(
  parameter int unsigned DB_CYCLES = gppm_pkg::DB_CYCLES,
  parameter int unsigned CNT_W     = gppm_pkg::CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic db,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DB_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  // Any agreement with the stable level zeroes the count, so glitches never accumulate.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CntLast) begin
        stable_d = sync2_q;
        rise_d   = sync2_q;
        fall_d   = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign db   = stable_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/sw_conditioner.sv
// Debounces SW_W raw switches and emits edge strobes; SW_CONDITIONER_TOGGLE_EN adds per-bit
// toggle latches driven by the rise strobes (sw_tgl reads 0 otherwise).
module sw_conditioner #(
  parameter int unsigned SW_W      = gppm_pkg::SW_W,
  parameter int unsigned DB_CYCLES = gppm_pkg::DB_CYCLES,
  parameter int unsigned CNT_W     = gppm_pkg::CNT_W
) (
  input logic              clk,
  input logic              reset,
  sw_conditioner_if.slave  bus
);

  logic [SW_W-1:0] db, rise, fall;

  for (genvar i = 0; i < SW_W; i++) begin : g_ch
    sw_debounce_bit #(
      .DB_CYCLES(DB_CYCLES),
      .CNT_W    (CNT_W)
    ) u_bit (
      .clk  (clk),
      .reset(reset),
      .raw  (bus.sw_raw[i]),
      .db   (db[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end

  assign bus.sw_db      = db;
  assign bus.sw_rise    = rise;
  assign bus.sw_fall    = fall;
  // Decoded purely from strobe flops, so it is glitch-free and aligned with them.
  assign bus.sw_changed = |(rise | fall);

`ifdef SW_CONDITIONER_TOGGLE_EN
  logic [SW_W-1:0] tgl_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tgl_q <= '0;
    end else begin
      tgl_q <= tgl_q ^ rise;
    end
  end

  assign bus.sw_tgl = tgl_q;
`else
  assign bus.sw_tgl = '0;
`endif

endmodule

// File: tb/tb_sw_conditioner.sv
// Scoreboard bench for sw_conditioner at DB_CYCLES_SIM: stimulus queues expected strobe events,
// a monitor pops and checks them whenever the DUT strobes.
`timescale 1ns/1ps
module tb_sw_conditioner;

  localparam int unsigned DB = gppm_pkg::DB_CYCLES_SIM;

  typedef struct {
    int         cyc;
    logic [7:0] rise;
    logic [7:0] fall;
    logic [7:0] db;
    logic [7:0] tgl;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t q[$];
  logic [7:0] db_m = 8'h00;
  logic [7:0] tgl_m = 8'h00;
`ifdef SW_CONDITIONER_TOGGLE_EN
  localparam bit TglEn = 1'b1;
`else
  localparam bit TglEn = 1'b0;
`endif

  sw_conditioner_if #(.SW_W(8)) bus ();

  sw_conditioner #(
    .SW_W     (8),
    .DB_CYCLES(DB),
    .CNT_W    (gppm_pkg::CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #100 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called on the negedge where sw_raw takes its new level; edge 1 is the next posedge.
  task automatic push(input logic [7:0] r, input logic [7:0] f);
    exp_t e;
    e.cyc  = cyc + int'(DB) + 2;
    db_m   = (db_m | r) & ~f;
    e.rise = r;
    e.fall = f;
    e.db   = db_m;
    e.tgl  = tgl_m;
    if (TglEn) tgl_m = tgl_m ^ r;
    q.push_back(e);
  endtask

  task automatic drive(input logic [7:0] v, input logic [7:0] r, input logic [7:0] f);
    bus.sw_raw = v;
    if ((r | f) != 8'h00) push(r, f);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        while (q.size() > 0 && cyc > q[0].cyc) begin
          chk("event_missing", cyc, q[0].cyc);
          void'(q.pop_front());
        end
        if ((bus.sw_rise | bus.sw_fall) != 8'h00 || bus.sw_changed) begin
          if (q.size() == 0) begin
            chk("unexpected_strobe", {bus.sw_rise, bus.sw_fall, 7'd0, bus.sw_changed}, 0);
          end else begin
            e = q.pop_front();
            chk("ev_cycle", cyc, e.cyc);
            chk("ev_rise", bus.sw_rise, e.rise);
            chk("ev_fall", bus.sw_fall, e.fall);
            chk("ev_db", bus.sw_db, e.db);
            chk("ev_changed", bus.sw_changed, 1);
            chk("ev_tgl", bus.sw_tgl, e.tgl);
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    bus.sw_raw = 8'hFF;
    reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("rst_db", bus.sw_db, 0);
      chk("rst_strobes", {bus.sw_rise, bus.sw_fall, bus.sw_changed}, 0);
      chk("rst_tgl", bus.sw_tgl, 0);
    end
    reset = 1'b1;
    push(8'hFF, 8'h00);
    wait_cyc(10);
    chk("all_high_db", bus.sw_db, 8'hFF);

    drive(8'h00, 8'h00, 8'hFF);
    wait_cyc(10);
    drive(8'h05, 8'h05, 8'h00);
    wait_cyc(10);
    chk("clean_db", bus.sw_db, 8'h05);
    drive(8'h00, 8'h00, 8'h05);
    wait_cyc(10);

    // 3-cycle pulse is rejected, 4-cycle pulse is accepted
    drive(8'h08, 8'h00, 8'h00);
    wait_cyc(3);
    drive(8'h00, 8'h00, 8'h00);
    wait_cyc(10);
    chk("glitch_db", bus.sw_db, 8'h00);
    drive(8'h08, 8'h08, 8'h00);
    wait_cyc(4);
    drive(8'h00, 8'h00, 8'h08);
    wait_cyc(10);

    for (int i = 0; i < 20; i++) begin
      bus.sw_raw = (i % 2 == 0) ? 8'h01 : 8'h00;
      @(negedge clk);
    end
    drive(8'h01, 8'h01, 8'h00);
    wait_cyc(10);
    chk("chatter_db", bus.sw_db, 8'h01);
    drive(8'h00, 8'h00, 8'h01);
    wait_cyc(10);

    // Fall interrupted by reset after edge 3
    drive(8'hFF, 8'hFF, 8'h00);
    wait_cyc(10);
    bus.sw_raw = 8'h00;
    wait_cyc(3);
    reset = 1'b0;
    #1;
    chk("midrst_db", bus.sw_db, 0);
    chk("midrst_strobes", {bus.sw_rise, bus.sw_fall, bus.sw_changed}, 0);
    chk("midrst_tgl", bus.sw_tgl, 0);
    db_m  = 8'h00;
    tgl_m = 8'h00;
    wait_cyc(2);
    reset = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("post_rst_db", bus.sw_db, 0);
    end

    drive(8'h80, 8'h80, 8'h00);
    wait_cyc(10);
    chk("tgl_first", bus.sw_tgl, TglEn ? 8'h80 : 8'h00);
    drive(8'h00, 8'h00, 8'h80);
    wait_cyc(10);
    drive(8'h80, 8'h80, 8'h00);
    wait_cyc(10);
    chk("tgl_second", bus.sw_tgl, 8'h00);

    chk("events_pending", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sw_conditioner.md
Name: sw_conditioner

Overview:
- Input-conditioning stage directly upstream of gppm_top: takes the 8 raw board slide switches and drives gppm_top's sw[7:0] with clean, glitch-free values.
- Per bit: 2-flop synchroniser, then counter-based debouncer.
- Also emits one-cycle rise/fall event strobes, so the LED effect logic can react to switch edges without doing its own edge detection.

Parameters:
- SW_W, 8, number of switch channels.
- DB_CYCLES, 250000, cycles the synchronised input must disagree with the debounced value before it is accepted; legal range 1..2**CNT_W-1.
- CNT_W, 18, debounce counter width; must satisfy 2**CNT_W > DB_CYCLES.

Ports:
- clk, input, 1, system clock; all state changes on the rising edge.
- reset, input, 1, asynchronous, active-low reset (reset==0 resets immediately; release is synchronous to clk at the integration level).
- sw_raw, input, SW_W, raw asynchronous switch pins.
- sw_db, output, SW_W, debounced switch levels; feeds gppm_top.sw.
- sw_rise, output, SW_W, one-cycle pulse per bit when sw_db goes 0->1.
- sw_fall, output, SW_W, one-cycle pulse per bit when sw_db goes 1->0.
- sw_changed, output, 1, OR-reduction of sw_rise|sw_fall, registered in the same cycle as the strobes.
- sw_tgl, output, SW_W, toggle-latched levels (see Optional Feature).

Behaviour:
- Reset (reset==0): sync1, sync2, stable, cnt, sw_rise, sw_fall, sw_changed and sw_tgl all clear to 0.
  - sw_db=0 while reset is asserted, regardless of sw_raw.
  - A reset asserted mid-count discards the count.
- Synchroniser: sync1<=sw_raw, sync2<=sync1 per bit. No logic reads sync1.
- Per-channel debounce, evaluated each edge:
  - sync2==stable: cnt<=0.
  - sync2!=stable and cnt<DB_CYCLES-1: cnt<=cnt+1.
  - sync2!=stable and cnt==DB_CYCLES-1: stable<=sync2, cnt<=0, and pulse rise or fall for one cycle according to the new value.
- sw_db equals stable (registered, no combinational path from sw_raw).
- Latency: call the first edge that samples a new sw_raw level "edge 1". sw_db and its strobe update at edge DB_CYCLES+2.
  - DB_CYCLES=1: edge 3.
- Glitch rejection: any return of sync2 to stable before the accept edge zeroes cnt. The next mismatch restarts the count from 0.
- Strobes:
  - sw_rise and sw_fall are registered and high for exactly one cycle, coincident with the edge on which sw_db changes.
  - A bit never has rise and fall together.
  - Multiple bits may strobe in the same cycle; sw_changed is then 1 for one cycle.
- Channels are fully independent. Simultaneous changes on several bits debounce in parallel with identical latency.
- cnt never exceeds DB_CYCLES-1, so there is no wrap-around.

Optional Feature:
- Macro: SW_CONDITIONER_TOGGLE_EN.
- Defined:
  - Each sw_tgl bit inverts on the edge where its sw_rise is 1, i.e. same edge as the strobe, so it is visible the cycle after.
  - sw_tgl resets to 0.
  - Lets push-buttons act as on/off mode selects.
- Undefined: sw_tgl is tied to 0; no toggle flops are instantiated.
- The port list is identical in both builds.

Decomposition:
- Package gppm_pkg holds:
  - SW_W default (8).
  - DB_CYCLES default for a 50 MHz board (250000 = 5 ms).
  - Simulation override constant DB_CYCLES_SIM=4.
  - CNT_W.
- One sub-module, sw_debounce_bit: one channel covering synchroniser, counter, stable flop and rise/fall strobes. It is instantiated SW_W times by a generate loop.
- The top level adds the sw_changed reduction and the optional toggle latches.

Test Plan (DB_CYCLES=4, clk period 200 ns, assertions sampled after each rising edge):
- Reset check: hold reset=0 with sw_raw=8'hFF for 5 cycles -> sw_db=8'h00, no strobes. Release reset -> sw_db=8'hFF at edge 6 after release; sw_rise=8'hFF and sw_changed=1 for exactly that cycle.
- Clean change: from sw_db=8'h00, set sw_raw=8'h05 before edge 1 -> sw_db=8'h05 at edge 6; sw_rise=8'h05 for one cycle; sw_fall=0.
- Glitch reject: pulse sw_raw[3] high for 3 cycles then low -> sw_db stays 8'h00, no strobe. Hold high for 4+ cycles -> accepted at edge 6.
- Chatter: toggle sw_raw[0] every cycle for 20 cycles, then hold 1 -> exactly one sw_rise[0] pulse, 6 edges after the final transition is first sampled.
- Fall and mid-count reset: sw_db=8'hFF, set sw_raw=8'h00, assert reset at edge 3 -> all outputs 0 immediately. Release with sw_raw=8'h00 -> no strobes for 10 cycles.
- Toggle (with SW_CONDITIONER_TOGGLE_EN): two accepted 0->1->0->1 cycles on bit 7 -> sw_tgl[7] goes 1 then 0. Without the macro, sw_tgl=8'h00 throughout.
